// File: rtl/dice_roll_ctrl.sv
// Purpose : dice roll sequencer; steps the face at a slowing rate after a start press, then holds the result.
// Latency : first tick BASE_DIV cycles after the accepted start edge; busy/face/stage registered, tick/done decoded from state.
// Backpressure: none; start edges during a roll are dropped, not queued.
//
// Ports:
//   clk_in  system clock, rising edge
//   rst     asynchronous active-high reset
//   start   debounced roll request (level; rising edge detected here)
//   face    current face 1..6
//   busy    high while rolling
//   tick    one-cycle strobe per face step
//   done    one-cycle strobe on the final face step
//   stage   current stage index, 0 when not rolling
module dice_roll_ctrl #(
    parameter int unsigned BASE_DIV        = 1000,
    parameter int unsigned STEP_DIV        = 500,
    parameter int unsigned STEPS_PER_STAGE = 4,
    parameter int unsigned NUM_STAGES      = 6
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       start,
    output logic [2:0] face,
    output logic       busy,
    output logic       tick,
    output logic       done,
    output logic [2:0] stage
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROLL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  seed;
    logic        start_d;
    logic [31:0] div_cnt;
    logic [31:0] div_lim;
    logic [31:0] step;

    logic        start_edge;
    logic        step_hit;
    logic        stage_end;
    logic        last_stage;

    assign start_edge = start & ~start_d;
    // A face step falls on the last cycle of the current step period.
    assign step_hit   = (state == S_ROLL) && (div_cnt == div_lim - 32'd1);
    assign stage_end  = (step == 32'(STEPS_PER_STAGE - 1));
    assign last_stage = (stage == 3'(NUM_STAGES - 1));

    assign tick = step_hit;
    assign done = step_hit & stage_end & last_stage;

    // State register
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; HOLD differs from IDLE only in the face it displays.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HOLD: begin
                if (start_edge) begin
                    state_nxt = S_ROLL;
                end
            end
            S_ROLL: begin
                if (done) begin
                    state_nxt = S_HOLD;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: seed, edge detect, divider, step/stage counters, face.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            seed    <= 3'd0;
            start_d <= 1'b0;
            face    <= 3'd1;
            busy    <= 1'b0;
            stage   <= 3'd0;
            step    <= 32'd0;
            div_cnt <= 32'd0;
            div_lim <= 32'(BASE_DIV);
        end else begin
            seed    <= (seed == 3'd5) ? 3'd0 : seed + 3'd1;
            start_d <= start;
            // Registered so busy covers the cycle after acceptance through the done cycle.
            busy    <= (state_nxt == S_ROLL);

            if (state != S_ROLL) begin
                if (start_edge) begin
                    face    <= seed + 3'd1;
                    stage   <= 3'd0;
                    step    <= 32'd0;
                    div_cnt <= 32'd0;
                    div_lim <= 32'(BASE_DIV);
                end
            end else if (step_hit) begin
                div_cnt <= 32'd0;
                face    <= (face == 3'd6) ? 3'd1 : face + 3'd1;
                if (stage_end) begin
                    step <= 32'd0;
                    if (last_stage) begin
                        stage <= 3'd0;
                    end else begin
                        stage   <= stage + 3'd1;
                        // Each later stage slows the animation by STEP_DIV cycles per step.
                        div_lim <= div_lim + 32'(STEP_DIV);
                    end
                end else begin
                    step <= step + 32'd1;
                end
            end else begin
                div_cnt <= div_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dice_roll_ctrl.sv
module tb_dice_roll_ctrl;

    localparam int BD  = 4;
    localparam int SD  = 2;
    localparam int SPS = 2;
    localparam int NS  = 3;

    logic       clk;
    logic       rst;
    logic       start;
    logic       start1;
    logic [2:0] face,  face1;
    logic       busy,  busy1;
    logic       tick,  tick1;
    logic       done,  done1;
    logic [2:0] stage, stage1;

    dice_roll_ctrl #(
        .BASE_DIV(BD), .STEP_DIV(SD), .STEPS_PER_STAGE(SPS), .NUM_STAGES(NS)
    ) dut (
        .clk_in(clk), .rst(rst), .start(start),
        .face(face), .busy(busy), .tick(tick), .done(done), .stage(stage)
    );

    dice_roll_ctrl #(
        .BASE_DIV(1), .STEP_DIV(0), .STEPS_PER_STAGE(2), .NUM_STAGES(3)
    ) dut1 (
        .clk_in(clk), .rst(rst), .start(start1),
        .face(face1), .busy(busy1), .tick(tick1), .done(done1), .stage(stage1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int m_seed;
    int busy_from = 1;
    int busy_to   = 0;
    int done_seen = 0;

    typedef struct {
        int cyc;
        int face;
        int stg;
        bit dn;
    } tick_t;

    tick_t q[$];
    tick_t r;

    typedef struct {
        int sd;
        bit hold;
        bit pulses;
    } row_t;

    row_t tbl[5];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference for the free-running seed the DUT samples on its start edge.
    always @(posedge clk or posedge rst) begin
        if (rst) m_seed <= 0;
        else     m_seed <= (m_seed == 5) ? 0 : m_seed + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every tick pops one expected step record.
    always @(negedge clk) begin
        if (!rst) begin
            check("busy", {31'd0, busy}, {31'd0, (cyc >= busy_from && cyc <= busy_to)});
            if (tick) begin
                if (q.size() == 0) begin
                    check("spurious_tick", {31'd0, tick}, 32'd0);
                end else begin
                    r = q.pop_front();
                    check("tick_cycle", cyc, r.cyc);
                    check("tick_face", {29'd0, face}, r.face);
                    check("tick_stage", {29'd0, stage}, r.stg);
                    check("tick_done", {31'd0, done}, {31'd0, r.dn});
                end
            end else begin
                check("done_without_tick", {31'd0, done}, 32'd0);
            end
            if (done) done_seen++;
        end
    end

    // Wait for the wanted seed, raise start and push the expected step records.
    task automatic launch(input int sd, output int n, output int len);
        int guard;
        int f;
        int per;
        start = 1'b0;
        guard = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (m_seed != sd && guard < 12);
        check("seed_sync", m_seed, sd);
        n     = cyc;
        start = 1'b1;
        len   = 0;
        f     = sd;
        for (int s = 0; s < NS; s++) begin
            per = BD + s * SD;
            for (int k = 0; k < SPS; k++) begin
                len += per;
                q.push_back('{cyc: n + len, face: (f % 6) + 1, stg: s,
                              dn: (s == NS - 1) && (k == SPS - 1)});
                f++;
            end
        end
        busy_from = n + 1;
        busy_to   = n + len;
    endtask

    task automatic pulse_at(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_roll(input int sd, input bit hold, input bit pulses);
        int n;
        int len;
        int d0;
        d0 = done_seen;
        launch(sd, n, len);
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        check("face_after_accept", {29'd0, face}, sd + 1);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        if (pulses) begin
            pulse_at(n + 5);
            pulse_at(n + 20);
        end
        while (q.size() != 0 && cyc < n + len + 20) begin
            @(posedge clk); #1;
        end
        if (q.size() != 0) begin
            check("roll_timeout_pending", q.size(), 0);
            q.delete();
        end
        while (cyc < n + len + 6) begin
            @(posedge clk); #1;
        end
        check("hold_face", {29'd0, face}, ((sd + NS * SPS) % 6) + 1);
        check("hold_stage", {29'd0, stage}, 32'd0);
        check("hold_busy", {31'd0, busy}, 32'd0);
        check("done_count", done_seen - d0, 1);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        int d0;
        int sd1;

        tbl[0] = '{sd: 2, hold: 1'b0, pulses: 1'b0};
        tbl[1] = '{sd: 4, hold: 1'b0, pulses: 1'b1};
        tbl[2] = '{sd: 0, hold: 1'b1, pulses: 1'b0};
        tbl[3] = '{sd: 3, hold: 1'b0, pulses: 1'b0};
        tbl[4] = '{sd: 5, hold: 1'b0, pulses: 1'b1};

        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs", {24'd0, face, busy, tick, done, stage},
                  {24'd0, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0});
        end

        for (int i = 0; i < 5; i++) begin
            do_roll(tbl[i].sd, tbl[i].hold, tbl[i].pulses);
        end

        // Reset in the middle of a roll.
        d0 = done_seen;
        launch(1, n, len);
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < n + 15) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        q.delete();
        busy_from = 1;
        busy_to   = 0;
        #1;
        check("rst_face", {29'd0, face}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stage", {29'd0, stage}, 32'd0);
        check("rst_tick_done", {30'd0, tick, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rst_no_done", done_seen - d0, 0);
        check("rst_idle_face", {29'd0, face}, 32'd1);
        do_roll(2, 1'b0, 1'b0);

        // Fastest divider: one face step per cycle.
        @(posedge clk); #1;
        sd1    = m_seed;
        start1 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) start1 = 1'b0;
            check("fast_tick", {31'd0, tick1}, {31'd0, (k <= 6)});
            check("fast_done", {31'd0, done1}, {31'd0, (k == 6)});
            check("fast_busy", {31'd0, busy1}, {31'd0, (k <= 6)});
            if (k <= 6) check("fast_face", {29'd0, face1}, ((sd1 + k - 1) % 6) + 1);
        end
        check("fast_final_face", {29'd0, face1}, ((sd1 + 6) % 6) + 1);
        check("fast_final_stage", {29'd0, stage1}, 32'd0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dice_roll_ctrl.md
# dice_roll_ctrl

Roll-sequence controller for the dice game. It owns a programmable tick divider, reloaded by stage, and steps the displayed face at a decelerating rate after a start press. It then freezes on the result and signals completion. It sits between the debounced start key and the face decoder / 7-segment and LED drivers, and replaces fixed-ratio prescaling for the roll animation.

## Interface
- BASE_DIV, 1000: input-clock cycles per face step in stage 0; must be ≥1.
- STEP_DIV, 500: cycles added to the step period at each stage advance; may be 0.
- STEPS_PER_STAGE, 4: face steps per stage; ≥1.
- NUM_STAGES, 6: stages per roll; 1..8.
- clk_in  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  synchronous, debounced roll request; level, rising-edge detected internally.
- face  output  3  current face value, 1..6.
- busy  output  1  high while rolling.
- tick  output  1  one-cycle strobe on every face step.
- done  output  1  one-cycle strobe on the final face step.
- stage  output  3  current stage index, 0..NUM_STAGES-1; 0 when not rolling.

## Operation
- Free-running seed counter, 0..5, increments every cycle, wraps 5→0; reset to 0. It is the only entropy source.
- Start edge = start & ~start_d, where start_d is a registered copy of start and resets to 0. If start is high on the first cycle after reset, that counts as an edge.
- States: IDLE, ROLL, HOLD. HOLD behaves as IDLE except face keeps the result.
- IDLE/HOLD + start edge → ROLL, with the following loads:
  - face ← seed+1
  - stage ← 0
  - step ← 0
  - div_cnt ← 0
  - div_lim ← BASE_DIV
- ROLL, each cycle: div_cnt increments.
- ROLL, when div_cnt == div_lim−1:
  - div_cnt ← 0; tick=1.
  - face advances 1→2→…→6→1.
  - step increments.
- ROLL, when that step closes the stage (step == STEPS_PER_STAGE−1):
  - step ← 0; stage increments; div_lim ← div_lim+STEP_DIV.
  - If stage == NUM_STAGES−1 instead: done=1 on the same cycle as tick, next state HOLD, stage ← 0.
- Start edges during ROLL are ignored; they are not queued.
- Start edge in HOLD begins a new roll from the current seed, not from the held face.
- Arithmetic: div_cnt and div_lim are 32-bit unsigned, no saturation. Integrators keep BASE_DIV+(NUM_STAGES−1)·STEP_DIV < 2^32.

## Timing
- Reset values:
  - face=1, busy=0, tick=0, done=0, stage=0
  - state IDLE, seed=0, start_d=0
- Reset mid-roll aborts immediately and asynchronously to those values. No done is produced.
- busy is registered: high from the cycle after the accepting edge through the cycle containing done; low from the next cycle.
- First tick comes BASE_DIV cycles after the accepting edge.
- Stage s has step period BASE_DIV+s·STEP_DIV cycles.
- Total roll length is STEPS_PER_STAGE·Σ_{s=0}^{NUM_STAGES−1}(BASE_DIV+s·STEP_DIV) cycles; defaults give 54000.
- Final face = ((seed_at_start + STEPS_PER_STAGE·NUM_STAGES) mod 6)+1.
- tick and done are single-cycle and never asserted outside ROLL.

## Test plan
Bench parameters: BASE_DIV=4, STEP_DIV=2, STEPS_PER_STAGE=2, NUM_STAGES=3.
- Reset, then idle 20 cycles → face=1, busy=0, tick=0, done=0, stage=0 throughout.
- Start edge sampled when seed=2:
  - face=3 next cycle, busy=1.
  - tick intervals 4,4,6,6,8,8 cycles.
  - face 4,5,6,1,2,3.
  - stage 0,0,1,1,2,2.
  - done with the 6th tick at cycle 36; busy=0 from cycle 37.
- Start pulses at cycles 5 and 20 of a roll → ignored; exactly 6 ticks, one done.
- rst asserted at cycle 15 of a roll:
  - face=1, busy=0, stage=0 immediately.
  - no done.
  - new start edge after release rolls normally.
- Start held high continuously across the whole roll and into HOLD → no retrigger; one roll only. Release and re-press in HOLD → new roll from the current seed.
- BASE_DIV=1, STEP_DIV=0 → tick every cycle during ROLL, 6 ticks, done on the last; busy high for exactly 6 cycles.
